muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute path of the core. Takes the two register-bank read operands (DOA/DOB) plus funct3 and destination index, computes over multiple cycles, and returns a result with write-enable and destination index that drive the register bank write port (DI, DIR_WR, REG_WR). One operation in flight at a time.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops early-out with result 0.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wr_en
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [4:0]        step;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   b_mag_q;
    logic [2*XLEN-1:0] acc;
    logic              neg_res;

    logic              a_sgn_op, b_sgn_op, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              early;
    logic [XLEN-1:0]   early_res;
    logic [2*XLEN-1:0] step_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;
    logic [XLEN:0]     mul_sum;

    always_comb begin
        a_sgn_op = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_sgn_op = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_sgn_op && op_a[XLEN-1];
        b_neg    = b_sgn_op && op_b[XLEN-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    end

    // acc holds {hi, lo}: product accumulator for multiply, {remainder, dividend/quotient} for divide
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : '0);
    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;

`ifdef MULDIV_DIV_EN
    logic              neg_rem;
    logic              div_zero, div_ovf;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN-1:0]   div_rem;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    assign div_zero  = (op_b == '0);
    assign div_ovf   = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    assign early     = funct3[2] && (div_zero || div_ovf);
    assign early_res = div_zero ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, b_mag_q};
    assign div_rem   = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign quo_fix   = neg_res ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    assign rem_fix   = neg_rem ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];

    always_comb begin
        if (op_q[2]) step_next = {div_rem, acc[XLEN-2:0], !div_diff[XLEN+1]};
        else         step_next = {mul_sum, acc[XLEN-1:1]};
    end

    always_comb begin
        fix_res = '0;
        case (op_q)
            3'b000:                 fix_res = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quo_fix;
            default:                fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 neg_rem <= 1'b0;
        else if (state == IDLE && start && !flush) neg_rem <= a_neg;
    end
`else
    assign early     = funct3[2];
    assign early_res = '0;
    assign step_next = {mul_sum, acc[XLEN-1:1]};

    always_comb begin
        fix_res = '0;
        if (op_q == 3'b000) fix_res = prod_fix[XLEN-1:0];
        else                fix_res = prod_fix[2*XLEN-1:XLEN];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            b_mag_q <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        op_q    <= funct3;
                        rd_q    <= rd_in;
                        b_mag_q <= b_mag;
                        neg_res <= a_neg ^ b_neg;
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        step    <= '0;
                        if (early) begin
                            result <= early_res;
                            rd_out <= rd_in;
                            state  <= DONE;
                        end else begin
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc  <= step_next;
                        step <= step + 5'd1;
                        if (step == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        rd_out <= rd_q;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE) && !flush;
    assign wr_en = done && (rd_out != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases plus randomized ops against an arithmetic model.
// Honours MULDIV_DIV_EN the same way as the design build.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        flush = 1'b0;
    logic        busy, done, wr_en;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int unsigned acc_cyc;
        int unsigned lat;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [31:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && !done && wr_en) begin
            checks++;
            failures++;
            $display("FAIL wr_en_without_done: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
                check("wr_en", {31'b0, wr_en}, {31'b0, (e.rd != 5'd0)});
                check("latency", cyc - e.acc_cyc, e.lat);
            end
        end
    end

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb_, ub;
        longint          ps;
        logic [63:0]     pu;
        int              ai, bi;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        ub = longint'({32'b0, b});
        pu = {32'b0, a} * {32'b0, b};
        ai = $signed(a);
        bi = $signed(b);
`ifndef MULDIV_DIV_EN
        if (f3[2]) return 32'h0;
`endif
        case (f3)
            3'd0: return pu[31:0];
            3'd1: begin ps = sa * sb_; return ps[63:32]; end
            3'd2: begin ps = sa * ub;  return ps[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ai / bi;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ai % bi;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f3[2];
`endif
    endfunction

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 (cycle %0d)", cyc);
        end
    endtask

    // Drives one request at an idle negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit track, input logic [31:0] eres, input bit early);
        exp_t e;
        wait_idle();
        funct3 = f3; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
        if (track) begin
            e.res = eres; e.rd = rd; e.acc_cyc = cyc + 1; e.lat = early ? 0 : 33;
            sb.push_back(e);
            last_res = eres;
        end
        @(negedge clk);
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    endtask

    task automatic directed(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] eres, input bit early);
`ifdef MULDIV_DIV_EN
        issue(f3, a, b, rd, 1'b1, eres, early);
`else
        issue(f3, a, b, rd, 1'b1, f3[2] ? 32'h0 : eres, f3[2] ? 1'b1 : early);
`endif
    endtask

    initial begin
        exp_t e;
        int unsigned a1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_wr_en", {31'b0, wr_en}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", {27'b0, rd_out}, 32'd0);
        rst_n = 1'b1;

        directed(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
        directed(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd6, 32'hFFFF_FFFF, 1'b0);
        directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b0);
        directed(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 1'b0);
        directed(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 1'b0);
        directed(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 1'b0);
        directed(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0);
        directed(3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 1'b0);
        directed(3'd5, 32'd100, 32'd0, 5'd14, 32'hFFFF_FFFF, 1'b1);
        directed(3'd7, 32'd100, 32'd0, 5'd15, 32'd100, 1'b1);
        directed(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1'b1);
        directed(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1'b1);
        directed(3'd0, 32'd3, 32'd5, 5'd0, 32'd15, 1'b0);
        directed(3'd0, 32'd3, 32'd5, 5'd9, 32'd15, 1'b0);

        // start held high: one op per acceptance, second accepted in the first IDLE cycle
        wait_idle();
        funct3 = 3'd0; op_a = 32'd6; op_b = 32'd7; rd_in = 5'd3; start = 1'b1;
        a1 = cyc + 1;
        e.res = 32'd42; e.rd = 5'd3; e.acc_cyc = a1; e.lat = 33;
        sb.push_back(e);
        repeat (5) @(negedge clk);
        op_a = 32'd10;
        e.res = 32'd70; e.rd = 5'd3; e.acc_cyc = a1 + 35; e.lat = 33;
        sb.push_back(e);
        last_res = 32'd70;
        while (cyc < a1 + 35) @(negedge clk);
        start = 1'b0;

        // flush and start together in IDLE: request dropped
        wait_idle();
        funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd1; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_start_idle_busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // flush at CALC step 10
        issue(3'd0, 32'd123, 32'd456, 5'd4, 1'b0, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 32'd0);
        check("flush_result_hold", result, last_res);
        check("flush_rd_hold", {27'b0, rd_out}, 32'd3);

        // async reset at step 20
        issue(3'd1, 32'd999, 32'd777, 5'd21, 1'b0, 32'd0, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("areset_busy", {31'b0, busy}, 32'd0);
        check("areset_done", {31'b0, done}, 32'd0);
        check("areset_result", result, 32'd0);
        check("areset_rd_out", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int unsigned r;
            f3 = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            rd = 5'($urandom_range(0, 31));
            r = $urandom_range(0, 9);
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (r == 2) b = 32'($urandom_range(1, 20));
            issue(f3, a, b, rd, 1'b1, ref_res(f3, a, b), ref_early(f3, a, b));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL missing_done: got %0d outstanding expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
